dump_seq: RTL and testbench
===========================

# dump_seq

Channel-dump sequencer for the logic analyzer. When the command configuration block decodes a dump command, it hands the channel number and the capture start address to this block. The block walks the selected channel's RAM queue circularly for ENTRIES samples and pushes each byte to the UART wrapper through the `send_resp`/`resp_sent` handshake. It sits between the five RAMqueue read ports and the UART transmit path.

## Interface
Parameters:
- ENTRIES, 384, depth of each channel RAM queue (samples dumped per command)
- LOG2, 9, address width; 2^LOG2 ≥ ENTRIES

Ports:
- clk  in  1  clock
- clr_cmd_rdy  in  1  reset: asynchronous, active-high; clock clk
- start  in  1  one-cycle dump request pulse
- ch_sel  in  3  channel to dump; valid values 1..5
- start_addr  in  LOG2  address of oldest sample (capture `ram_addr`); sampled with start
- rdataCH1..rdataCH5  in  8 each  RAMqueue read data; synchronous, 1-cycle latency
- resp_sent  in  1  UART finished transmitting current byte
- raddr  out  LOG2  shared read address to all RAMqueues
- resp  out  8  byte to transmit
- send_resp  out  1  one-cycle transmit strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last byte is acknowledged
- err  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, RD, CAP, SEND, WAIT, DONE.
- IDLE:
  - start=1 with ch_sel in 1..5 and start_addr<ENTRIES: latch the channel, set raddr←start_addr and cnt←0, go to RD.
  - start=1 with an invalid ch_sel (0, 6, 7) or start_addr≥ENTRIES: pulse err for one cycle, stay in IDLE, no send_resp.
- RD: one cycle while the RAM registers raddr. Go to CAP.
- CAP: resp←rdata of the latched channel (5:1 mux). Go to SEND.
- SEND: send_resp=1 for exactly this cycle. Go to WAIT.
- WAIT: hold resp and raddr until resp_sent=1.
  - If cnt==ENTRIES-1, go to DONE.
  - Otherwise: cnt←cnt+1; raddr←(raddr==ENTRIES-1)?0:raddr+1; go to RD.
- DONE: done=1 for one cycle, then IDLE.
- cnt is LOG2 bits wide. Address wrap happens at ENTRIES-1, not at 2^LOG2-1.
- start is ignored while busy=1. ch_sel and start_addr are ignored outside the IDLE start cycle.
- resp_sent is ignored in every state except WAIT, including a resp_sent coincident with send_resp.
- Exactly ENTRIES send_resp pulses per accepted start, in circular order from start_addr.

## Timing
- Reset values: state=IDLE, raddr=0, cnt=0, resp=0x00, send_resp=0, busy=0, done=0, err=0.
- Reset is asynchronous. Asserting clr_cmd_rdy mid-dump forces all outputs to their reset values immediately, without waiting for a clock edge. No further send_resp is issued. A byte already in flight in the UART is not recalled.
- Let E0 be the edge that samples start.
  - raddr is valid after E0.
  - The RAM latches rdata at E1.
  - resp is captured at E2.
  - send_resp is high in the cycle after E2.
  - done/err pulse: err is high in the cycle after E0; done is high in the cycle after the edge that exits WAIT on the last byte.
- Per-byte overhead: the edge sampling resp_sent=1 is followed by send_resp for the next byte 3 cycles later.
- resp is stable from SEND through the end of WAIT.
- busy rises after E0 and falls on the edge that leaves DONE.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- Full dump: load RAM1 with mem[a]=(a+1) mod 256; start, ch_sel=1, start_addr=0 → 384 send_resp pulses with bytes 0x01..0xFF, 0x00, 0x01..0x80; exactly one done pulse; busy low afterwards.
- Wrap-around: start_addr=383, ch_sel=1 → first byte mem[383]=0x80, second mem[0]=0x01, last mem[382]=0x7F; raddr never exceeds 383.
- Invalid request: ch_sel=0, then 6, then start_addr=400 → one err pulse each cycle after start; send_resp and busy stay 0.
- Channel mux: RAMn filled with constant 0x10·n; start with ch_sel=5 → every resp=0x50. A start with ch_sel=2 pulsed mid-dump is ignored: no error, and the stream stays 0x50.
- Reset mid-operation: assert clr_cmd_rdy after the 10th resp_sent → send_resp, busy and raddr go to 0 immediately. A fresh start with start_addr=7 then restarts with resp=mem[7].
- Handshake: resp_sent coincident with send_resp is ignored (no advance); resp_sent held high for 3 cycles in WAIT advances exactly one byte; a 3-cycle gap from resp_sent to the next send_resp is measured.

Source files
------------

// File: rtl/dump_seq.sv
// Channel-dump sequencer: walks one channel RAM queue circularly from the
// capture start address and streams every sample to the UART wrapper, one
// byte per send_resp/resp_sent handshake.
module dump_seq #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic            clk,
  input  logic            clr_cmd_rdy,
  input  logic            start,
  input  logic [2:0]      ch_sel,
  input  logic [LOG2-1:0] start_addr,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  input  logic            resp_sent,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      resp,
  output logic            send_resp,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StCap  = 3'd2;
  localparam logic [2:0] StSend = 3'd3;
  localparam logic [2:0] StWait = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  // Highest legal address; both the sample counter and the address wrap here.
  localparam logic [LOG2-1:0] LastIdx = LOG2'(ENTRIES - 1);

  logic [2:0]      state_q, state_d;
  logic [2:0]      ch_q, ch_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]      resp_q, resp_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_sel;
  logic            req_ok;

  assign req_ok = (ch_sel != 3'd0) && (ch_sel <= 3'd5) && (start_addr <= LastIdx);

  // Select the read data of the channel latched at start.
  always_comb begin
    rdata_sel = 8'h00;
    case (ch_q)
      3'd1:    rdata_sel = rdataCH1;
      3'd2:    rdata_sel = rdataCH2;
      3'd3:    rdata_sel = rdataCH3;
      3'd4:    rdata_sel = rdataCH4;
      3'd5:    rdata_sel = rdataCH5;
      default: rdata_sel = 8'h00;
    endcase
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    raddr_d = raddr_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (req_ok) begin
            ch_d    = ch_sel;
            raddr_d = start_addr;
            cnt_d   = '0;
            state_d = StRd;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // RAM registers raddr on the edge leaving this state.
      StRd:   state_d = StCap;
      StCap: begin
        resp_d  = rdata_sel;
        state_d = StSend;
      end
      StSend: state_d = StWait;
      StWait: begin
        if (resp_sent) begin
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            raddr_d = (raddr_q == LastIdx) ? '0 : raddr_q + 1'b1;
            state_d = StRd;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; clr_cmd_rdy clears everything at once.
  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      state_q <= StIdle;
      ch_q    <= 3'd0;
      raddr_q <= '0;
      cnt_q   <= '0;
      resp_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from the state register only, so no input reaches an output.
  assign raddr     = raddr_q;
  assign resp      = resp_q;
  assign send_resp = (state_q == StSend);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;

endmodule

// File: tb/tb_dump_seq.sv
// Bench for dump_seq: RAM queue models, a UART-side responder driven from the
// stimulus sequence, and an expected stream of mem[ch][(start+i) mod ENTRIES].
module tb_dump_seq;

  localparam int unsigned ENTRIES = 384;
  localparam int unsigned LOG2    = 9;

  logic            clk = 1'b0;
  logic            clr_cmd_rdy;
  logic            start;
  logic [2:0]      ch_sel;
  logic [LOG2-1:0] start_addr;
  logic [7:0]      rd1, rd2, rd3, rd4, rd5;
  logic            resp_sent;
  logic [LOG2-1:0] raddr;
  logic [7:0]      resp;
  logic            send_resp, busy, done, err;

  logic [7:0] mem [1:5][0:ENTRIES-1];

  int n_cmp = 0;
  int n_bad = 0;
  int send_cnt, done_cnt, err_cnt;
  int unsigned max_raddr;

  always #5 clk = ~clk;

  dump_seq #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk        (clk),
    .clr_cmd_rdy(clr_cmd_rdy),
    .start      (start),
    .ch_sel     (ch_sel),
    .start_addr (start_addr),
    .rdataCH1   (rd1),
    .rdataCH2   (rd2),
    .rdataCH3   (rd3),
    .rdataCH4   (rd4),
    .rdataCH5   (rd5),
    .resp_sent  (resp_sent),
    .raddr      (raddr),
    .resp       (resp),
    .send_resp  (send_resp),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Synchronous-read RAM queues, one cycle of latency.
  always @(posedge clk) begin
    rd1 <= mem[1][raddr];
    rd2 <= mem[2][raddr];
    rd3 <= mem[3][raddr];
    rd4 <= mem[4][raddr];
    rd5 <= mem[5][raddr];
  end

  // Event counters sampled on the active edge (pre-edge values).
  always @(posedge clk) begin
    if (send_resp) send_cnt <= send_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (32'(raddr) > max_raddr) max_raddr <= 32'(raddr);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    send_cnt  = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    max_raddr = 0;
  endtask

  task automatic issue_start(input int ch, input int sa);
    start      = 1'b1;
    ch_sel     = 3'(ch);
    start_addr = LOG2'(sa);
    @(negedge clk);
    start      = 1'b0;
    ch_sel     = 3'($urandom);
    start_addr = LOG2'($urandom);
  endtask

  task automatic wait_send(output bit ok);
    for (int k = 0; k < 20 && !send_resp; k++) @(negedge clk);
    ok = send_resp;
    chk("send_seen", 32'(send_resp), 32'd1);
  endtask

  // Acknowledge bytes from..to-1 of a dump, checking each against the model.
  task automatic serve(input int ch, input int sa, input int from, input int to,
                       input int maxd, input int inject);
    bit ok;
    int idx;
    int d;
    for (int i = from; i < to; i++) begin
      wait_send(ok);
      if (!ok) return;
      idx = (sa + i) % ENTRIES;
      chk("resp", 32'(resp), 32'(mem[ch][idx]));
      chk("raddr", 32'(raddr), 32'(idx));
      @(negedge clk);
      chk("send_width", 32'(send_resp), 32'd0);
      d = int'($urandom_range(maxd, 0));
      repeat (d) @(negedge clk);
      chk("resp_hold", 32'(resp), 32'(mem[ch][idx]));
      if (i == inject) begin
        start      = 1'b1;
        ch_sel     = 3'd2;
        start_addr = '0;
      end
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
      start     = 1'b0;
    end
  endtask

  task automatic check_done();
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic full_dump(input int ch, input int sa, input int maxd, input int inject);
    clear_counts();
    issue_start(ch, sa);
    serve(ch, sa, 0, ENTRIES, maxd, inject);
    check_done();
    chk("send_count", 32'(send_cnt), ENTRIES);
    chk("done_count", 32'(done_cnt), 32'd1);
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < ENTRIES; a++) mem[1][a] = 8'((a + 1) % 256);
  endtask

  initial begin
    bit ok;
    int gap;
    int sa;
    clr_cmd_rdy = 1'b1;
    start       = 1'b0;
    ch_sel      = 3'd0;
    start_addr  = '0;
    resp_sent   = 1'b0;
    clear_counts();
    for (int c = 1; c <= 5; c++)
      for (int a = 0; a < ENTRIES; a++) mem[c][a] = 8'($urandom);
    fill_pattern();

    // Reset values
    #1;
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_send", 32'(send_resp), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Full dump from address 0, immediate acknowledge
    full_dump(1, 0, 0, -1);

    // Wrap-around from the last address
    full_dump(1, ENTRIES - 1, 3, -1);
    chk("max_raddr", 32'(max_raddr), ENTRIES - 1);

    // Rejected requests
    clear_counts();
    issue_start(0, 5);
    chk("err_ch0", 32'(err), 32'd1);
    chk("busy_ch0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_ch0_width", 32'(err), 32'd0);
    issue_start(6, 5);
    chk("err_ch6", 32'(err), 32'd1);
    chk("busy_ch6", 32'(busy), 32'd0);
    @(negedge clk);
    issue_start(1, 400);
    chk("err_addr", 32'(err), 32'd1);
    chk("busy_addr", 32'(busy), 32'd0);
    @(negedge clk);
    issue_start(7, 0);
    chk("err_ch7", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    chk("err_count", 32'(err_cnt), 32'd4);
    chk("err_no_send", 32'(send_cnt), 32'd0);
    chk("err_idle", 32'(busy), 32'd0);

    // Handshake: coincident resp_sent ignored, long resp_sent advances once
    clear_counts();
    sa = 20;
    issue_start(1, sa);
    wait_send(ok);
    chk("hs_resp0", 32'(resp), 32'(mem[1][sa]));
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
    chk("hs_wait_send", 32'(send_resp), 32'd0);
    chk("hs_wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hs_no_adv_raddr", 32'(raddr), 32'(sa));
    chk("hs_no_adv_resp", 32'(resp), 32'(mem[1][sa]));
    chk("hs_no_adv_send", 32'(send_resp), 32'd0);
    resp_sent = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!send_resp && gap < 10);
    resp_sent = 1'b0;
    chk("hs_gap", 32'(gap), 32'd3);
    serve(1, sa, 1, ENTRIES, 1, -1);
    check_done();
    chk("hs_send_count", 32'(send_cnt), ENTRIES);

    // Channel mux with an ignored start mid-dump
    for (int c = 1; c <= 5; c++)
      for (int a = 0; a < ENTRIES; a++) mem[c][a] = 8'(16 * c);
    full_dump(5, int'($urandom_range(ENTRIES - 1, 0)), 2, 5);
    chk("mux_no_err", 32'(err_cnt), 32'd0);

    // Random contents, channels and start addresses
    for (int c = 1; c <= 5; c++)
      for (int a = 0; a < ENTRIES; a++) mem[c][a] = 8'($urandom);
    repeat (2) full_dump(int'($urandom_range(5, 1)), int'($urandom_range(ENTRIES - 1, 0)), 3, -1);
    full_dump(2, int'($urandom_range(ENTRIES - 1, 0)), 1, -1);

    // Reset in the middle of a dump, then restart at address 7
    fill_pattern();
    issue_start(1, int'($urandom_range(ENTRIES - 1, 0)));
    serve(1, 0, 0, 0, 0, -1);
    begin
      int sa2;
      sa2 = 100;
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      @(negedge clk);
      issue_start(1, sa2);
      serve(1, sa2, 0, 10, 2, -1);
    end
    #1 clr_cmd_rdy = 1'b1;
    #1;
    chk("mid_rst_send", 32'(send_resp), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_raddr", 32'(raddr), 32'd0);
    chk("mid_rst_resp", 32'(resp), 32'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    clear_counts();
    repeat (6) @(negedge clk);
    chk("mid_rst_quiet", 32'(send_cnt), 32'd0);
    full_dump(1, 7, 2, -1);

    chk("final_idle", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
